// File: rtl/alien_bomb_engine.sv
// rtl/alien_bomb_engine.sv - alien bomb spawner, mover, ship collision, lives and game-over tracking
// One fire attempt every FIRE_PERIOD ticks drops a bomb under a pseudo-randomly chosen living alien.
module alien_bomb_engine #(
  parameter int NUM_BOMBS     = 3,
  parameter int FIRE_PERIOD   = 40,
  parameter int BOMB_STEP     = 4,
  parameter int SHIP_Y        = 400,
  parameter int HIT_HALF_W    = 12,
  parameter int HIT_HALF_H    = 8,
  parameter int SCREEN_BOTTOM = 470,
  parameter int LIVES_INIT    = 3,
  parameter int FREEZE_TICKS  = 60
) (
  input  logic                   Clk,
  input  logic                   reset_n,
  input  logic                   tick,
  input  logic                   enable,
  input  logic [149:0]           alien_x,
  input  logic [14:0]            alien_alive,
  input  logic [9:0]             topY,
  input  logic [9:0]             midY,
  input  logic [9:0]             botY,
  input  logic [9:0]             ship_x,
  output logic [10*NUM_BOMBS-1:0] bomb_x,
  output logic [10*NUM_BOMBS-1:0] bomb_y,
  output logic [NUM_BOMBS-1:0]   bomb_valid,
  output logic                   ship_hit,
  output logic [2:0]             lives,
  output logic                   game_over
);

  localparam int FCW = $clog2(FIRE_PERIOD + 1);
  localparam int ZCW = $clog2(FREEZE_TICKS + 1);
  localparam logic [9:0] EMPTY_X = 10'd900;

  typedef enum logic [1:0] {RUN, FREEZE, OVER} state_t;

  state_t               state, state_n;
  logic [15:0]          lfsr;
  logic [FCW-1:0]       fire_cnt, fire_cnt_n;
  logic [ZCW-1:0]       freeze_cnt, freeze_cnt_n;
  logic [9:0]           bx [NUM_BOMBS];
  logic [9:0]           bx_n [NUM_BOMBS];
  logic [9:0]           by [NUM_BOMBS];
  logic [9:0]           by_n [NUM_BOMBS];
  logic [NUM_BOMBS-1:0] bv, bv_n;
  logic [2:0]           lives_n;
  logic                 hit_n;
  logic [9:0]           ax [15];

  genvar g;
  for (g = 0; g < 15; g++) begin : g_alien
    assign ax[g] = alien_x[10*g +: 10];
  end
  for (g = 0; g < NUM_BOMBS; g++) begin : g_slot
    assign bomb_x[10*g +: 10] = bx[g];
    assign bomb_y[10*g +: 10] = by[g];
  end
  assign bomb_valid = bv;

  // Wrap-around scan from the random start; descending loop lets the nearest alive alien win.
  logic [3:0] start, idx, tgt_alien;
  logic [4:0] sum;
  logic       alien_found;
  logic [9:0] spawn_y;
  always_comb begin
    start       = (lfsr[3:0] == 4'd15) ? 4'd0 : lfsr[3:0];
    alien_found = 1'b0;
    tgt_alien   = 4'd0;
    sum         = 5'd0;
    idx         = 4'd0;
    for (int j = 14; j >= 0; j--) begin
      sum = {1'b0, start} + 5'(j);
      idx = (sum >= 5'd15) ? 4'(sum - 5'd15) : sum[3:0];
      if (alien_alive[idx]) begin
        alien_found = 1'b1;
        tgt_alien   = idx;
      end
    end
    if (tgt_alien < 4'd5)       spawn_y = topY + 10'd10;
    else if (tgt_alien < 4'd10) spawn_y = midY + 10'd10;
    else                        spawn_y = botY + 10'd10;
  end

  int   tgt_slot;
  logic slot_found;
  always_comb begin
    tgt_slot   = 0;
    slot_found = 1'b0;
    for (int i = NUM_BOMBS - 1; i >= 0; i--) begin
      if (!bv[i]) begin
        tgt_slot   = i;
        slot_found = 1'b1;
      end
    end
  end

  logic [10:0] ny, dy;
  logic [9:0]  dx;
  logic        any_hit, fire_now;
  always_comb begin
    state_n      = state;
    fire_cnt_n   = fire_cnt;
    freeze_cnt_n = freeze_cnt;
    bx_n         = bx;
    by_n         = by;
    bv_n         = bv;
    lives_n      = lives;
    hit_n        = 1'b0;
    ny           = 11'd0;
    dy           = 11'd0;
    dx           = 10'd0;
    any_hit      = 1'b0;
    fire_now     = 1'b0;
    if (tick && enable) begin
      case (state)
        RUN: begin
          if (fire_cnt == FCW'(FIRE_PERIOD - 1)) begin
            fire_cnt_n = '0;
            fire_now   = 1'b1;
          end else begin
            fire_cnt_n = fire_cnt + 1'b1;
          end
          for (int i = 0; i < NUM_BOMBS; i++) begin
            if (bv[i]) begin
              ny = {1'b0, by[i]} + 11'(BOMB_STEP);
              dy = (ny >= 11'(SHIP_Y)) ? ny - 11'(SHIP_Y) : 11'(SHIP_Y) - ny;
              dx = (bx[i] >= ship_x) ? bx[i] - ship_x : ship_x - bx[i];
              if (ny >= 11'(SCREEN_BOTTOM)) begin
                bv_n[i] = 1'b0;
                bx_n[i] = EMPTY_X;
                by_n[i] = 10'd0;
              end else if (dy <= 11'(HIT_HALF_H) && dx <= 10'(HIT_HALF_W)) begin
                any_hit = 1'b1;
              end else begin
                by_n[i] = ny[9:0];
              end
            end
          end
          // Slot choice uses occupancy before this tick, so a freed slot is not reused yet.
          if (fire_now && alien_found && slot_found) begin
            bv_n[tgt_slot] = 1'b1;
            bx_n[tgt_slot] = ax[tgt_alien];
            by_n[tgt_slot] = spawn_y;
          end
          if (any_hit) begin
            hit_n      = 1'b1;
            lives_n    = (lives == 3'd0) ? 3'd0 : lives - 3'd1;
            bv_n       = '0;
            fire_cnt_n = '0;
            for (int i = 0; i < NUM_BOMBS; i++) begin
              bx_n[i] = EMPTY_X;
              by_n[i] = 10'd0;
            end
            if (lives_n == 3'd0) begin
              state_n = OVER;
            end else begin
              state_n      = FREEZE;
              freeze_cnt_n = '0;
            end
          end
        end
        FREEZE: begin
          if (freeze_cnt == ZCW'(FREEZE_TICKS - 1)) begin
            state_n      = RUN;
            fire_cnt_n   = '0;
            freeze_cnt_n = '0;
          end else begin
            freeze_cnt_n = freeze_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RUN;
      lfsr       <= 16'hACE1;
      fire_cnt   <= '0;
      freeze_cnt <= '0;
      bv         <= '0;
      lives      <= 3'(LIVES_INIT);
      ship_hit   <= 1'b0;
      game_over  <= 1'b0;
      for (int i = 0; i < NUM_BOMBS; i++) begin
        bx[i] <= EMPTY_X;
        by[i] <= 10'd0;
      end
    end else begin
      lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      state      <= state_n;
      fire_cnt   <= fire_cnt_n;
      freeze_cnt <= freeze_cnt_n;
      bv         <= bv_n;
      bx         <= bx_n;
      by         <= by_n;
      lives      <= lives_n;
      ship_hit   <= hit_n;
      game_over  <= (state_n == OVER);
    end
  end

endmodule

// File: tb/tb_alien_bomb_engine.sv
// tb/tb_alien_bomb_engine.sv - directed self-checking bench for alien_bomb_engine
// A second instance with a short fire period exercises the all-slots-full case.
module tb_alien_bomb_engine;

  localparam int NB = 3;

  logic           Clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           tick = 1'b0;
  logic           enable = 1'b0;
  logic [149:0]   alien_x;
  logic [14:0]    alien_alive = 15'h7fff;
  logic [9:0]     topY = 10'd30;
  logic [9:0]     midY = 10'd90;
  logic [9:0]     botY = 10'd150;
  logic [9:0]     ship_x = 10'd600;
  logic [10*NB-1:0] bomb_x, bomb_y, bomb_x2, bomb_y2;
  logic [NB-1:0]  bomb_valid, bomb_valid2;
  logic           ship_hit, ship_hit2, game_over, game_over2;
  logic [2:0]     lives, lives2;

  int vectors = 0;
  int miscompares = 0;

  alien_bomb_engine dut (
    .Clk(Clk), .reset_n(reset_n), .tick(tick), .enable(enable),
    .alien_x(alien_x), .alien_alive(alien_alive), .topY(topY), .midY(midY), .botY(botY),
    .ship_x(ship_x), .bomb_x(bomb_x), .bomb_y(bomb_y), .bomb_valid(bomb_valid),
    .ship_hit(ship_hit), .lives(lives), .game_over(game_over)
  );

  alien_bomb_engine #(.FIRE_PERIOD(8)) dut2 (
    .Clk(Clk), .reset_n(reset_n), .tick(tick), .enable(enable),
    .alien_x(alien_x), .alien_alive(alien_alive), .topY(topY), .midY(midY), .botY(botY),
    .ship_x(ship_x), .bomb_x(bomb_x2), .bomb_y(bomb_y2), .bomb_valid(bomb_valid2),
    .ship_hit(ship_hit2), .lives(lives2), .game_over(game_over2)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_tick();
    repeat (3) @(negedge Clk);
    tick = 1'b1;
    @(negedge Clk);
    tick = 1'b0;
  endtask

  task automatic do_reset();
    tick = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    reset_n = 1'b1;
    @(negedge Clk);
  endtask

  initial begin
    int bad, bad2, bad3, kf;
    logic [9:0] ey, fy0, fy1, fy2;

    for (int k = 0; k < 15; k++) alien_x[10*k +: 10] = 10'(90 + 20*k);

    // Test 1: reset values, then first spawn on the 40th tick
    do_reset();
    check("rst_valid", 32'(bomb_valid), 0);
    check("rst_bomb_x", 32'(bomb_x), {2'b0, 10'd900, 10'd900, 10'd900});
    check("rst_bomb_y", 32'(bomb_y), 0);
    check("rst_ship_hit", 32'(ship_hit), 0);
    check("rst_lives", 32'(lives), 3);
    check("rst_game_over", 32'(game_over), 0);
    enable = 1'b1;
    alien_alive = 15'h7fff;
    ship_x = 10'd600;
    bad = 0;
    for (int t = 1; t < 40; t++) begin
      do_tick();
      if (bomb_valid !== '0) bad++;
    end
    check("t1_no_early_bomb", 32'(bad), 0);
    do_tick();
    check("t1_slot0_valid", 32'(bomb_valid), 1);
    kf = -1;
    for (int k = 0; k < 15; k++) if (alien_x[10*k +: 10] == bomb_x[9:0]) kf = k;
    check("t1_x_is_alien", 32'(kf >= 0), 1);
    ey = (kf < 5) ? 10'd40 : (kf < 10) ? 10'd100 : 10'd160;
    check("t1_y_row", 32'(bomb_y[9:0]), 32'(ey));

    // Test 2: single alien, bomb falls and is freed at the bottom
    do_reset();
    alien_alive = 15'h0080;
    repeat (40) do_tick();
    check("t2_spawn_x", 32'(bomb_x[9:0]), 230);
    check("t2_spawn_y", 32'(bomb_y[9:0]), 100);
    bad = 0;
    for (int k = 1; k <= 93; k++) begin
      do_tick();
      if (k < 93) begin
        if (bomb_y[9:0] !== 10'(100 + 4*k)) bad++;
      end
      if (k == 40) begin
        check("t2_two_slots", 32'(bomb_valid), 3);
        check("t2_slot1_x", 32'(bomb_x[19:10]), 230);
        check("t2_slot1_y", 32'(bomb_y[19:10]), 100);
      end
    end
    check("t2_fall_steps", 32'(bad), 0);
    check("t2_freed_valid", 32'(bomb_valid), 6);
    check("t2_freed_x", 32'(bomb_x[9:0]), 900);
    check("t2_freed_y", 32'(bomb_y[9:0]), 0);

    // Test 3: ship under the alien, hit at ny=392
    do_reset();
    ship_x = 10'd230;
    repeat (40) do_tick();
    repeat (72) do_tick();
    check("t3_prehit_valid", 32'(bomb_valid), 3);
    check("t3_prehit_y", 32'(bomb_y[9:0]), 388);
    check("t3_prehit_hit", 32'(ship_hit), 0);
    do_tick();
    check("t3_hit_pulse", 32'(ship_hit), 1);
    check("t3_lives", 32'(lives), 2);
    check("t3_cleared", 32'(bomb_valid), 0);
    check("t3_cleared_x", 32'(bomb_x), {2'b0, 10'd900, 10'd900, 10'd900});
    @(negedge Clk);
    check("t3_hit_one_clk", 32'(ship_hit), 0);
    bad = 0;
    for (int t = 0; t < 99; t++) begin
      do_tick();
      if (bomb_valid !== '0) bad++;
    end
    check("t3_freeze_no_spawn", 32'(bad), 0);
    do_tick();
    check("t3_respawn_valid", 32'(bomb_valid), 1);
    check("t3_respawn_y", 32'(bomb_y[9:0]), 100);

    // Test 4: two more hits end the game
    repeat (72) do_tick();
    do_tick();
    check("t4_hit2", 32'(ship_hit), 1);
    check("t4_lives1", 32'(lives), 1);
    check("t4_not_over", 32'(game_over), 0);
    repeat (99) do_tick();
    do_tick();
    check("t4_respawn2", 32'(bomb_valid), 1);
    repeat (72) do_tick();
    do_tick();
    check("t4_hit3", 32'(ship_hit), 1);
    check("t4_lives0", 32'(lives), 0);
    check("t4_game_over", 32'(game_over), 1);
    bad = 0; bad2 = 0; bad3 = 0;
    for (int t = 0; t < 500; t++) begin
      do_tick();
      if (bomb_valid !== '0) bad++;
      if (game_over !== 1'b1) bad2++;
      if (lives !== 3'd0) bad3++;
    end
    check("t4_over_no_bombs", 32'(bad), 0);
    check("t4_over_sticky", 32'(bad2), 0);
    check("t4_lives_floor", 32'(bad3), 0);

    // Test 5: no aliens alive, then only alien 14
    do_reset();
    ship_x = 10'd600;
    alien_alive = 15'h0000;
    bad = 0;
    for (int t = 0; t < 400; t++) begin
      do_tick();
      if (bomb_valid !== '0) bad++;
    end
    check("t5_no_alive", 32'(bad), 0);
    alien_alive = 15'h4000;
    repeat (39) do_tick();
    check("t5_wait", 32'(bomb_valid), 0);
    do_tick();
    check("t5_spawn_valid", 32'(bomb_valid), 1);
    check("t5_spawn_x", 32'(bomb_x[9:0]), 370);
    check("t5_spawn_y", 32'(bomb_y[9:0]), 160);

    // Test 6: slots full (short-period instance), then pause
    do_reset();
    ship_x = 10'd1000;
    alien_alive = 15'h0001;
    repeat (40) do_tick();
    check("t6_full_valid", 32'(bomb_valid2), 7);
    check("t6_full_y", 32'(bomb_y2), {2'b0, 10'd104, 10'd136, 10'd168});
    check("t6_full_x", 32'(bomb_x2), {2'b0, 10'd90, 10'd90, 10'd90});
    check("t6_main_spawn", 32'(bomb_y[9:0]), 40);
    fy0 = bomb_y2[9:0]; fy1 = bomb_y2[19:10]; fy2 = bomb_y2[29:20];
    enable = 1'b0;
    repeat (20) do_tick();
    check("t6_pause_y", 32'(bomb_y2), {2'b0, fy2, fy1, fy0});
    check("t6_pause_main_y", 32'(bomb_y[9:0]), 40);
    enable = 1'b1;
    bad = 0;
    for (int t = 0; t < 39; t++) begin
      do_tick();
      if (bomb_valid !== 3'b001) bad++;
    end
    check("t6_cnt_held", 32'(bad), 0);
    do_tick();
    check("t6_second_spawn", 32'(bomb_valid), 3);
    check("t6_slot0_y", 32'(bomb_y[9:0]), 200);
    check("t6_slot1_y", 32'(bomb_y[19:10]), 40);

    // Asynchronous reset mid-fall
    @(negedge Clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(bomb_valid), 0);
    check("arst_bomb_x", 32'(bomb_x), {2'b0, 10'd900, 10'd900, 10'd900});
    check("arst_bomb_y", 32'(bomb_y), 0);
    check("arst_lives", 32'(lives), 3);
    check("arst_valid2", 32'(bomb_valid2), 0);
    check("arst_lives2", 32'(lives2), 3);
    check("arst_flags2", 32'({ship_hit2, game_over2}), 0);
    check("arst_flags", 32'({ship_hit, game_over}), 0);
    @(negedge Clk);
    reset_n = 1'b1;
    @(negedge Clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
